// File: rtl/pool_window_gen.sv
// Streaming 2x2 stride-2 window generator feeding max_pool; buffers one row and emits registered windows.
// Optional build macro: POOL_WIN_RELU_EN clamps negative pixels to zero before storage or output.
module pool_window_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic signed [DATA_WIDTH-1:0] in_data_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic signed [DATA_WIDTH-1:0] win_o [0:3],
    output logic                         win_valid_o,
    input  logic                         win_ready_i,
    output logic                         win_last_o
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] colQ, colD, colPrev;
    logic [ROW_W-1:0] rowQ, rowD;

    logic signed [DATA_WIDTH-1:0] lineBufQ [IMG_WIDTH];
    logic signed [DATA_WIDTH-1:0] blQ, blD;
    logic signed [DATA_WIDTH-1:0] winQ [0:3];
    logic signed [DATA_WIDTH-1:0] winD [0:3];
    logic                         winValidQ, winValidD;
    logic                         winLastQ, winLastD;

    logic                         accept;
    logic                         isBot;
    logic                         colLast;
    logic                         rowLast;
    logic                         load;
    logic                         consume;
    logic signed [DATA_WIDTH-1:0] pixel;

    // A pending window blocks every input pixel, so nothing can ever overwrite it.
    assign in_ready_o = !winValidQ || win_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign consume    = winValidQ && win_ready_i;

`ifdef POOL_WIN_RELU_EN
    assign pixel = in_data_i[DATA_WIDTH-1] ? '0 : in_data_i;
`else
    assign pixel = in_data_i;
`endif

    assign isBot   = rowQ[0];
    assign colLast = (colQ == COL_LAST);
    assign rowLast = (rowQ == ROW_LAST);
    assign colPrev = colQ - COL_W'(1);
    assign load    = accept && isBot && colQ[0];

    always_comb begin
        colD = colQ;
        rowD = rowQ;
        if (accept) begin
            if (colLast) begin
                colD = '0;
                rowD = rowLast ? '0 : rowQ + ROW_W'(1);
            end else begin
                colD = colQ + COL_W'(1);
            end
        end
    end

    // On an odd-column bottom pixel the window completes; a load always wins over a clear.
    always_comb begin
        blD       = blQ;
        winD      = winQ;
        winValidD = winValidQ;
        winLastD  = winLastQ;
        if (accept && isBot && !colQ[0]) begin
            blD = pixel;
        end
        if (load) begin
            winD[0]   = lineBufQ[colPrev];
            winD[1]   = lineBufQ[colQ];
            winD[2]   = blQ;
            winD[3]   = pixel;
            winValidD = 1'b1;
            winLastD  = rowLast && colLast;
        end else if (consume) begin
            winValidD = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            colQ      <= '0;
            rowQ      <= '0;
            blQ       <= '0;
            winValidQ <= 1'b0;
            winLastQ  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                winQ[i] <= '0;
            end
        end else begin
            colQ      <= colD;
            rowQ      <= rowD;
            blQ       <= blD;
            winValidQ <= winValidD;
            winLastQ  <= winLastD;
            winQ      <= winD;
        end
    end

    // The row buffer is always rewritten by a top row before it is read, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (accept && !isBot) begin
            lineBufQ[colQ] <= pixel;
        end
    end

    assign win_o       = winQ;
    assign win_valid_o = winValidQ;
    assign win_last_o  = winLastQ;

endmodule

// File: tb/tb_pool_window_gen.sv
// Self-checking bench for pool_window_gen on a 4x4 frame: vector table plus stall, random, reset and ReLU sequences.
module tb_pool_window_gen;

    localparam int DW = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] inData = '0;
    logic                 inValid = 1'b0;
    logic                 inReady;
    logic signed [DW-1:0] win [0:3];
    logic                 winValid;
    logic                 winReady = 1'b1;
    logic                 winLast;

    int compareCount  = 0;
    int mismatchCount = 0;

    always #5 clk = ~clk;

    pool_window_gen #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (4),
        .IMG_HEIGHT(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_data_i  (inData),
        .in_valid_i (inValid),
        .in_ready_o (inReady),
        .win_o      (win),
        .win_valid_o(winValid),
        .win_ready_i(winReady),
        .win_last_o (winLast)
    );

    typedef struct packed {
        logic                inValid;
        logic [DW-1:0]       inData;
        logic                winReady;
        logic                expInReady;
        logic                expValid;
        logic                expLast;
        logic [3:0][DW-1:0]  expWin;
    } vec_t;

    vec_t vecs [18];

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, $signed(actual), $signed(expected));
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r);
        inValid  = v;
        inData   = d;
        winReady = r;
    endtask

    task automatic checkWindow(input string name, input logic [3:0][DW-1:0] expWin);
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("%s lane%0d", name, j), win[j], expWin[j]);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset valid", {31'b0, winValid}, 32'd0);
        checkOutput("reset last", {31'b0, winLast}, 32'd0);
        checkOutput("reset inReady", {31'b0, inReady}, 32'd1);
        checkWindow("reset win", '0);
    endtask

    // Expected window w of a frame stream whose pixel n has value base+n.
    function automatic logic [3:0][DW-1:0] expWindow(input int base, input int w);
        logic [3:0][DW-1:0] e;
        int f, k, tl;
        f  = w / 4;
        k  = w % 4;
        tl = base + 16 * f + 8 * (k / 2) + 2 * (k % 2);
        e[0] = DW'(tl);
        e[1] = DW'(tl + 1);
        e[2] = DW'(tl + 4);
        e[3] = DW'(tl + 5);
        return e;
    endfunction

    // mode 0: continuous; mode 1: hold ready low for 3 cycles at the first window; mode 2: random valid/ready.
    task automatic runStream(input int base, input int nFrames, input int mode);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int stall = 0;
        bit stallDone = 0;
        bit prevHeld = 0;
        logic signed [DW-1:0] prevWin [4];
        int total = nFrames * 16;
        logic [3:0][DW-1:0] firstWin;
        firstWin = expWindow(base, 0);
        while (got < nFrames * 4 && cyc < 2000) begin
            @(negedge clk);
            if (sent < total && (mode != 2 || $urandom_range(0, 2) != 0)) begin
                inValid = 1'b1;
                inData  = DW'(base + sent);
            end else begin
                inValid = 1'b0;
            end
            if (mode == 1 && !stallDone && stall == 0 && winValid) begin
                stall = 3;
            end
            winReady = (stall > 0) ? 1'b0 : (mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1);
            #1;
            if (stall > 0) begin
                checkOutput("stall inReady", {31'b0, inReady}, 32'd0);
                checkOutput("stall valid", {31'b0, winValid}, 32'd1);
                checkWindow("stall win", firstWin);
                stall--;
                if (stall == 0) stallDone = 1;
            end
            if (prevHeld) begin
                for (int j = 0; j < 4; j++) begin
                    checkOutput($sformatf("held lane%0d", j), win[j], prevWin[j]);
                end
            end
            if (winValid && winReady) begin
                checkWindow($sformatf("stream win%0d", got), expWindow(base, got));
                checkOutput($sformatf("stream last%0d", got), {31'b0, winLast},
                            {31'b0, (got % 4) == 3});
                got++;
            end
            if (inValid && inReady) sent++;
            prevHeld = winValid && !winReady;
            for (int j = 0; j < 4; j++) prevWin[j] = win[j];
            cyc++;
        end
        checkOutput("stream window count", got, nFrames * 4);
        if (mode == 1) checkOutput("stall happened", {31'b0, stallDone}, 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b1);
    endtask

    initial begin
        logic [3:0][DW-1:0] reluExp;

        for (int i = 0; i < 18; i++) begin
            vecs[i]            = '0;
            vecs[i].inValid    = (i < 16);
            vecs[i].inData     = (i < 16) ? DW'(i) : '0;
            vecs[i].winReady   = 1'b1;
            vecs[i].expInReady = 1'b1;
        end
        vecs[6].expValid  = 1'b1;
        vecs[6].expWin    = {32'd5, 32'd4, 32'd1, 32'd0};
        vecs[8].expValid  = 1'b1;
        vecs[8].expWin    = {32'd7, 32'd6, 32'd3, 32'd2};
        vecs[14].expValid = 1'b1;
        vecs[14].expWin   = {32'd13, 32'd12, 32'd9, 32'd8};
        vecs[16].expValid = 1'b1;
        vecs[16].expLast  = 1'b1;
        vecs[16].expWin   = {32'd15, 32'd14, 32'd11, 32'd10};

        doReset();

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].inValid, vecs[i].inData, vecs[i].winReady);
            #1;
            checkOutput($sformatf("vec%0d inReady", i), {31'b0, inReady}, {31'b0, vecs[i].expInReady});
            checkOutput($sformatf("vec%0d valid", i), {31'b0, winValid}, {31'b0, vecs[i].expValid});
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d last", i), {31'b0, winLast}, {31'b0, vecs[i].expLast});
                checkWindow($sformatf("vec%0d win", i), vecs[i].expWin);
            end
        end

        doReset();
        runStream(0, 1, 1);

        doReset();
        runStream(0, 2, 2);

        doReset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, DW'(i), 1'b1);
        end
        doReset();
        runStream(100, 1, 0);

        doReset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            case (i)
                0: applyStimulus(1'b1, -32'sd5, 1'b1);
                1: applyStimulus(1'b1, 32'sd3, 1'b1);
                2: applyStimulus(1'b1, 32'sd10, 1'b1);
                3: applyStimulus(1'b1, 32'sd11, 1'b1);
                4: applyStimulus(1'b1, -32'sd1, 1'b1);
                default: applyStimulus(1'b1, -32'sd7, 1'b1);
            endcase
        end
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b1);
        #1;
`ifdef POOL_WIN_RELU_EN
        reluExp = {32'd0, 32'd0, 32'd3, 32'd0};
`else
        reluExp = {-32'sd7, -32'sd1, 32'sd3, -32'sd5};
`endif
        checkOutput("relu valid", {31'b0, winValid}, 32'd1);
        checkWindow("relu win", reluExp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/pool_window_gen.md
# pool_window_gen

Streaming 2x2 window generator that sits directly upstream of the `max_pool` stage in the CNN datapath. It accepts a raster-order feature map, one signed pixel per handshake, from the convolution/activation stage. It buffers one row and emits non-overlapping 2x2 windows (stride 2) in the `pool_window[0:3]` order that `max_pool` consumes. Output is a registered valid/ready stream with a last-window flag per frame.

## Interface
- `DATA_WIDTH`, 32, signed pixel width; must match `max_pool`.
- `IMG_WIDTH`, 28, pixels per row; even, ≥2.
- `IMG_HEIGHT`, 28, rows per frame; even, ≥2.

- `clk_i`  in  1  sole clock; all state updates on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `in_data_i`  in  DATA_WIDTH  signed pixel, raster order (row-major, column 0 first).
- `in_valid_i`  in  1  `in_data_i` valid.
- `in_ready_o`  out  1  pixel accepted when `in_valid_i && in_ready_o`.
- `win_o[0:3]`  out  4×DATA_WIDTH  window: [0]=top-left, [1]=top-right, [2]=bottom-left, [3]=bottom-right.
- `win_valid_o`  out  1  `win_o` valid.
- `win_ready_i`  in  1  window consumed when `win_valid_o && win_ready_i`.
- `win_last_o`  out  1  qualifies `win_o`; high on the final window of a frame.

## Operation
- Counters:
  - `col` counts 0..IMG_WIDTH-1.
  - `row` counts 0..IMG_HEIGHT-1.
  - Both advance only on an accepted input pixel.
  - `col` wraps to 0 and increments `row`; `row` wraps to 0 after the last pixel of the frame.
- State is implicit in `row[0]`:
  - **TOP** (even row): each accepted pixel is written to `line_buf[col]` (IMG_WIDTH entries).
  - **BOT** (odd row), even `col`: the pixel is stored in `bl_reg`.
  - **BOT** (odd row), odd `col`: a window is formed as {`line_buf[col-1]`, `line_buf[col]`, `bl_reg`, `in_data_i`} and loaded into the output register.
- Output register:
  - Loaded with `win_valid_o`←1 and `win_last_o`←(row==IMG_HEIGHT-1 && col==IMG_WIDTH-1).
  - Cleared (`win_valid_o`←0) on a consume with no simultaneous load.
  - Simultaneous consume and load: the new window replaces the old one and valid stays 1.
- `in_ready_o = !win_valid_o || win_ready_i` (combinational, all states). This is conservative: it also stalls TOP-row pixels while a window is pending. A window is never dropped or overwritten.
- Output is held stable (data, valid, last) while `win_valid_o && !win_ready_i`.
- Frames are back-to-back; no gap is required between the last pixel of one frame and the first pixel of the next.
- Arithmetic: no computation; pixels pass bit-exact, except as described under Configuration.

## Timing
- Latency: the window appears on `win_o` with `win_valid_o`=1 in the cycle after the bottom-right pixel is accepted.
- Throughput: 1 pixel/cycle with `win_ready_i` held high. Sustained rate is IMG_WIDTH·IMG_HEIGHT/4 windows per frame.
- Reset (`rst_i`=1 at a clock edge):
  - `row`, `col`, `win_valid_o`, `win_last_o`, `bl_reg` and `win_o` are cleared to 0.
  - `line_buf` contents need not be cleared; they are overwritten before any read.
  - `in_ready_o` reads 1 in the first cycle after reset.
- Reset mid-frame: the partial frame and any pending window are discarded. The next accepted pixel is treated as row 0, col 0.
- `in_valid_i` low: no counter or buffer change; a pending window is still consumable.

## Configuration
- `POOL_WIN_RELU_EN` defined: each accepted pixel is clamped to 0 if negative, before storage or output. This fuses ReLU ahead of pooling, so `max_pool` sees only non-negative values.
- Not defined: pixels pass unmodified; negative values reach `win_o` unchanged.

## Test plan
- IMG_WIDTH=IMG_HEIGHT=4, pixels 0..15 streamed continuously, `win_ready_i`=1:
  - Required windows are {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}.
  - `win_last_o`=1 only on the 4th window.
  - Each window is valid 1 cycle after pixels 5, 7, 13, 15 respectively.
- Same frame, `win_ready_i` low for 3 cycles after window 1 asserts:
  - `win_o` is held at {0,1,4,5}.
  - `in_ready_o`=0 for those cycles.
  - No pixel is lost; the subsequent windows are unchanged.
- Random `in_valid_i` and `win_ready_i` toggling over two back-to-back 4x4 frames: 8 windows, in order, matching a reference model; `win_last_o` on windows 4 and 8.
- Assert `rst_i` after pixel 9 of a frame, then stream a fresh frame 100..115:
  - All outputs read 0 after reset.
  - The first window is {100,101,104,105}.
- With `POOL_WIN_RELU_EN` defined, the first window's input pixels are -5, 3, -1, -7: required window {0,3,0,0}. Without the macro the same input gives {-5,3,-1,-7}.
